bcd_counter_ndigit: RTL and testbench
=====================================

// Module: bcd_counter_ndigit
// PURPOSE
//  Parametrised multi-digit BCD up/down counter. It is the successor to the single-decade counter.
//  It measures HC-SR04 echo width and the pot/tone period in decimal, for 7-segment display.
//  Adds: N cascaded decades, direction, enable, parallel load, snapshot capture, wrap/saturate mode,
//  and sticky overflow. Sits between the echo-gate timing logic and the display multiplexer.
// PARAMETERS
//  DIGITS    4  number of BCD decades (1..8); digit 0 = least significant
//  SATURATE  0  0: wrap at 9..9 / 0..0 boundaries; 1: hold at the boundary
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high; clears all state
//  clear       in   1         synchronous clear of count and overflow
//  enable      in   1         count one step this cycle
//  up          in   1         1: increment, 0: decrement (sampled only when enable=1)
//  load        in   1         synchronous parallel load
//  load_value  in   4*DIGITS  BCD load word; nibble k = digit k
//  capture     in   1         snapshot request
//  count       out  4*DIGITS  live BCD count (registered)
//  captured    out  4*DIGITS  last snapshot (registered)
//  carry_out   out  1         one-cycle pulse on a wrap in either direction
//  overflow    out  1         sticky: set on any step attempted past a boundary
//  at_zero     out  1         combinational: count == 0
// BEHAVIOUR
//  Reset (async): count=0, captured=0, carry_out=0, overflow=0. Reset takes effect mid-count immediately.
//  Per-edge priority: reset > clear > load > enable. Lower-priority actions in the same cycle are ignored.
//  clear: count=0, overflow=0, carry_out=0.
//  load: each nibble >9 is clamped to 9 and written. overflow is unchanged. carry_out=0.
//  enable, up=1:
//   - Digit k increments when all lower digits ==9. A digit at 9 rolls to 0 and ripples.
//   - Count 9..9 (all digits): SATURATE=0 -> count=0, carry_out=1, overflow=1.
//   - Count 9..9 (all digits): SATURATE=1 -> count holds, carry_out=0, overflow=1.
//  enable, up=0:
//   - Digit k decrements when all lower digits ==0. A digit at 0 rolls to 9.
//   - Count 0..0: SATURATE=0 -> count=9..9, carry_out=1, overflow=1.
//   - Count 0..0: SATURATE=1 -> count holds, carry_out=0, overflow=1.
//  No enable/load/clear: count holds, carry_out=0.
//  Latency: count and carry_out update on the same edge that samples the controls (1 clock).
//  capture: on the edge, captured <= count value *before* that edge's update. This applies even with
//   clear, load or enable in the same cycle. Otherwise captured holds.
//  carry_out is never high for two consecutive cycles unless wraps occur on consecutive enabled cycles.
//  Digits of count are always legal BCD (0..9). No illegal state is reachable, including after load.
//  All arithmetic is per nibble. No binary-to-BCD conversion is performed.
// STRUCTURE
//  Shared package/header (theremin_defs):
//   - BCD_MAX=4'd9, BCD_ZERO=4'd0
//   - function bcd_clamp(nibble)
//  Sub-module bcd_digit:
//   - one decade; inputs step, up, load, clear, load_nibble
//   - outputs digit, at_max (==9), at_min (==0)
//   - instantiated DIGITS times via generate
//  Top level:
//   - builds the ripple enables from the at_max/at_min prefix-AND chain
//   - holds overflow, carry_out, captured and the saturate gating
// TESTING
//  1 DIGITS=4, wrap mode:
//    reset, then enable up x10 -> count=0x0010, carry_out never high, at_zero=0 after 1st step.
//  2 load 0x9998, enable up x2 -> 0x9999, then 0x0000.
//    carry_out=1 for exactly the 2nd cycle; overflow=1 and stays 1 until clear.
//  3 SATURATE=1: load 0x0001, enable down x3 -> 0x0000, 0x0000, 0x0000.
//    carry_out stays 0; overflow=1 from the 2nd step.
//  4 load 0xA3F7 -> count=0x9397 (clamped).
//    Same cycle load+enable -> load wins, count = load value, no step.
//  5 count=0x0123, capture+clear same cycle -> captured=0x0123, count=0x0000, overflow=0.
//    capture+enable up -> captured = pre-step value.
//  6 Assert reset asynchronously between edges during counting.
//    All outputs go to 0 without waiting for a clock; counting resumes from 0 after release.

Source files
------------

// File: rtl/bcd_counter_ndigit_pkg.sv
// Shared BCD definitions for the display-timing counters.
// Holds the decade limits and the nibble clamp used on parallel load.
package theremin_defs;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // Out-of-range nibbles are pinned to 9 so a load can never create an illegal digit.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
      logic [3:0] result;
      if (nibble > BCD_MAX) begin
         result = BCD_MAX;
      end else begin
         result = nibble;
      end
      return result;
   endfunction

   // Next value of one decade for a single step; rolls 9->0 up and 0->9 down.
   function automatic logic [3:0] bcd_step(input logic [3:0] nibble, input logic up);
      logic [3:0] result;
      if (up) begin
         if (nibble >= BCD_MAX) begin
            result = BCD_ZERO;
         end else begin
            result = nibble + 4'd1;
         end
      end else begin
         if (nibble == BCD_ZERO) begin
            result = BCD_MAX;
         end else begin
            result = nibble - 4'd1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/bcd_counter_ndigit_digit.sv
// One BCD decade: clear > load > step, with boundary flags for the ripple chain.
module bcd_digit
   import theremin_defs::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_nibble,
   input  logic       step,
   input  logic       up,
   output logic [3:0] digit,
   output logic       at_max,
   output logic       at_min
);

   logic [3:0] r_digit;

   // Decade register with async reset and prioritised synchronous controls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_digit <= BCD_ZERO;
      end else if (clear) begin
         r_digit <= BCD_ZERO;
      end else if (load) begin
         r_digit <= bcd_clamp(load_nibble);
      end else if (step) begin
         r_digit <= bcd_step(r_digit, up);
      end else begin
         r_digit <= r_digit;
      end
   end

   assign digit  = r_digit;
   assign at_max = (r_digit == BCD_MAX);
   assign at_min = (r_digit == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Multi-decade BCD up/down counter with load, snapshot, wrap/saturate and sticky overflow.
// Feeds the 7-segment multiplexer with echo-width and tone-period values.
module bcd_counter_ndigit
   import theremin_defs::*;
#(
   parameter int DIGITS   = 4,
   parameter int SATURATE = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic                  capture,
   output logic [4*DIGITS-1:0]   count,
   output logic [4*DIGITS-1:0]   captured,
   output logic                  carry_out,
   output logic                  overflow,
   output logic                  at_zero
);

   localparam logic SAT_EN = (SATURATE != 0);

   logic [DIGITS:0]       w_lower_max;
   logic [DIGITS:0]       w_lower_min;
   logic [DIGITS-1:0]     w_at_max;
   logic [DIGITS-1:0]     w_at_min;
   logic [DIGITS-1:0]     w_step;
   logic [4*DIGITS-1:0]   w_count;
   logic                  w_count_en;
   logic                  w_boundary;
   logic                  w_sat_hold;

   logic [4*DIGITS-1:0]   r_captured;
   logic                  r_carry;
   logic                  r_overflow;

   assign w_lower_max[0] = 1'b1;
   assign w_lower_min[0] = 1'b1;

   // A decade moves only when every lower decade sits at the boundary for this direction.
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         assign w_lower_max[k+1] = w_lower_max[k] & w_at_max[k];
         assign w_lower_min[k+1] = w_lower_min[k] & w_at_min[k];
         assign w_step[k] = w_count_en & ~w_sat_hold &
                            (up ? w_lower_max[k] : w_lower_min[k]);

         bcd_digit u_digit (
            .clock       (clock),
            .reset       (reset),
            .clear       (clear),
            .load        (load),
            .load_nibble (load_value[4*k +: 4]),
            .step        (w_step[k]),
            .up          (up),
            .digit       (w_count[4*k +: 4]),
            .at_max      (w_at_max[k]),
            .at_min      (w_at_min[k])
         );
      end
   endgenerate

   // Step qualification and boundary detection for the whole word.
   always_comb begin
      w_count_en = 1'b0;
      w_boundary = 1'b0;
      w_sat_hold = 1'b0;
      w_count_en = enable & ~clear & ~load;
      if (up) begin
         w_boundary = w_lower_max[DIGITS];
      end else begin
         w_boundary = w_lower_min[DIGITS];
      end
      w_sat_hold = SAT_EN & w_boundary;
   end

   // Wrap pulse and sticky overflow; load leaves overflow untouched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (load) begin
         r_carry    <= 1'b0;
         r_overflow <= r_overflow;
      end else if (w_count_en) begin
         r_carry    <= w_boundary & ~SAT_EN;
         r_overflow <= r_overflow | w_boundary;
      end else begin
         r_carry    <= 1'b0;
         r_overflow <= r_overflow;
      end
   end

   // Snapshot takes the pre-update count regardless of other controls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_captured <= {(4*DIGITS){1'b0}};
      end else if (capture) begin
         r_captured <= w_count;
      end else begin
         r_captured <= r_captured;
      end
   end

   assign count     = w_count;
   assign captured  = r_captured;
   assign carry_out = r_carry;
   assign overflow  = r_overflow;
   assign at_zero   = w_lower_min[DIGITS];

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench: a wrap-mode and a saturate-mode counter driven by the same controls.
module tb_bcd_counter_ndigit;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear;
   logic        enable;
   logic        up;
   logic        load;
   logic [15:0] load_value;
   logic        capture;

   logic [15:0] a_count, a_captured, b_count, b_captured;
   logic        a_carry, a_ovf, a_zero, b_carry, b_ovf, b_zero;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   bcd_counter_ndigit #(.DIGITS(4), .SATURATE(0)) u_wrap (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable), .up(up),
      .load(load), .load_value(load_value), .capture(capture),
      .count(a_count), .captured(a_captured), .carry_out(a_carry),
      .overflow(a_ovf), .at_zero(a_zero)
   );

   bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1)) u_sat (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable), .up(up),
      .load(load), .load_value(load_value), .capture(capture),
      .count(b_count), .captured(b_captured), .carry_out(b_carry),
      .overflow(b_ovf), .at_zero(b_zero)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      clear = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; capture = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      load_value = 16'h0000;
      idle();
      #12;
      chk("rst_count",    a_count,    16'h0000);
      chk("rst_captured", a_captured, 16'h0000);
      chk("rst_carry",    {15'd0, a_carry}, 16'h0000);
      chk("rst_ovf",      {15'd0, a_ovf},   16'h0000);
      chk("rst_zero",     {15'd0, a_zero},  16'h0001);
      reset = 1'b0;

      // 1: count up ten times in wrap mode
      enable = 1'b1; up = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("t1_count", a_count, 16'((i / 10) * 16 + (i % 10)));
         chk("t1_carry", {15'd0, a_carry}, 16'h0000);
         if (i == 1) chk("t1_zero", {15'd0, a_zero}, 16'h0000);
      end
      chk("t1_final", a_count, 16'h0010);

      // 2: wrap from 9999
      idle(); load = 1'b1; load_value = 16'h9998;
      tick();
      chk("t2_load", a_count, 16'h9998);
      idle(); enable = 1'b1; up = 1'b1;
      tick();
      chk("t2_9999", a_count, 16'h9999);
      chk("t2_c1",   {15'd0, a_carry}, 16'h0000);
      chk("t2_o1",   {15'd0, a_ovf},   16'h0000);
      tick();
      chk("t2_wrap", a_count, 16'h0000);
      chk("t2_c2",   {15'd0, a_carry}, 16'h0001);
      chk("t2_o2",   {15'd0, a_ovf},   16'h0001);
      chk("t2_sat_count", b_count, 16'h9999);
      chk("t2_sat_carry", {15'd0, b_carry}, 16'h0000);
      chk("t2_sat_ovf",   {15'd0, b_ovf},   16'h0001);
      idle();
      tick();
      chk("t2_c3",   {15'd0, a_carry}, 16'h0000);
      chk("t2_o3",   {15'd0, a_ovf},   16'h0001);
      clear = 1'b1;
      tick();
      chk("t2_clr_ovf",   {15'd0, a_ovf}, 16'h0000);
      chk("t2_clr_count", b_count, 16'h0000);

      // 3: count down through zero; saturate holds, wrap rolls to 9999
      idle(); load = 1'b1; load_value = 16'h0001;
      tick();
      idle(); enable = 1'b1; up = 1'b0;
      tick();
      chk("t3_s1_count", b_count, 16'h0000);
      chk("t3_s1_ovf",   {15'd0, b_ovf}, 16'h0000);
      tick();
      chk("t3_s2_count", b_count, 16'h0000);
      chk("t3_s2_carry", {15'd0, b_carry}, 16'h0000);
      chk("t3_s2_ovf",   {15'd0, b_ovf},   16'h0001);
      chk("t3_w2_count", a_count, 16'h9999);
      chk("t3_w2_carry", {15'd0, a_carry}, 16'h0001);
      tick();
      chk("t3_s3_count", b_count, 16'h0000);
      chk("t3_s3_carry", {15'd0, b_carry}, 16'h0000);
      chk("t3_w3_count", a_count, 16'h9998);
      chk("t3_w3_carry", {15'd0, a_carry}, 16'h0000);

      // 4: clamped load, load beats enable, overflow kept across load
      idle(); load = 1'b1; load_value = 16'hA3F7;
      tick();
      chk("t4_clamp",    a_count, 16'h9397);
      chk("t4_ovf_keep", {15'd0, a_ovf}, 16'h0001);
      load_value = 16'h0042; enable = 1'b1; up = 1'b1;
      tick();
      chk("t4_load_wins", a_count, 16'h0042);
      chk("t4_carry",     {15'd0, a_carry}, 16'h0000);

      // 5: capture with clear, capture with step, ripple borrow
      idle(); load = 1'b1; load_value = 16'h0123;
      tick();
      idle(); capture = 1'b1; clear = 1'b1;
      tick();
      chk("t5_cap_clr",   a_captured, 16'h0123);
      chk("t5_count_clr", a_count,    16'h0000);
      chk("t5_ovf_clr",   {15'd0, a_ovf}, 16'h0000);
      idle(); load = 1'b1; load_value = 16'h0123;
      tick();
      idle(); capture = 1'b1; enable = 1'b1; up = 1'b1;
      tick();
      chk("t5_cap_step",   a_captured, 16'h0123);
      chk("t5_count_step", a_count,    16'h0124);
      idle(); load = 1'b1; load_value = 16'h1000;
      tick();
      idle(); enable = 1'b1; up = 1'b0;
      tick();
      chk("t5_borrow",   a_count,    16'h0999);
      chk("t5_cap_hold", a_captured, 16'h0123);

      // 6: asynchronous reset between edges while counting up
      idle(); enable = 1'b1; up = 1'b1;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      chk("t6_count",    a_count,    16'h0000);
      chk("t6_captured", a_captured, 16'h0000);
      chk("t6_ovf",      {15'd0, a_ovf},  16'h0000);
      chk("t6_carry",    {15'd0, a_carry}, 16'h0000);
      chk("t6_zero",     {15'd0, a_zero},  16'h0001);
      #1 reset = 1'b0;
      tick();
      chk("t6_resume1", a_count, 16'h0001);
      tick();
      chk("t6_resume2", a_count, 16'h0002);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
